// File: rtl/pwm_capture_if.sv
// Bundles the line samples and measurement results of pwm_capture.
//   din        line samples, bit 0 earliest in time
//   period     rise-to-rise time in fine units
//   high_time  rise-to-fall time in fine units
//   meas_valid 1-clk pulse when period/high_time are updated
//   ovf        1-clk pulse when no closing edge arrives in time
//   glitch     1-clk pulse when a word holds more than one edge of a kind
// master: line source / result consumer; slave: the capture block.
interface pwm_capture_if #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned HRBITS = 3
);
  logic [2**HRBITS-1:0] din;
  logic [WIDTH-2:0]     period;
  logic [WIDTH-2:0]     high_time;
  logic                 meas_valid;
  logic                 ovf;
  logic                 glitch;

  modport master (
    output din,
    input  period, high_time, meas_valid, ovf, glitch
  );

  modport slave (
    input  din,
    output period, high_time, meas_valid, ovf, glitch
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM line delivered as deserialized
// sample words (2**HRBITS samples per clock), in fine sub-clock units.
//   i_clk  system clock
//   i_rst  synchronous reset, active high
//   bus    pwm_capture_if slave: din in; period, high_time, meas_valid,
//          ovf, glitch out (all outputs registered)
module pwm_capture #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned HRBITS = 3
) (
  input logic          i_clk,
  input logic          i_rst,
  pwm_capture_if.slave bus
);
  localparam int unsigned N  = 2**HRBITS;
  localparam int unsigned PW = WIDTH - 1;
  localparam int unsigned EW = PW - HRBITS;
  localparam logic [EW-1:0] ElMax = '1;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e            r_state, w_state_d;
  logic              r_prev_bit;
  logic [EW-1:0]     r_elapsed, w_elapsed_d, w_el;
  logic [HRBITS-1:0] r_t_rise, w_t_rise_d;
  logic [PW-1:0]     r_high_acc, w_high_acc_d;
  logic [PW-1:0]     r_period, w_period_d;
  logic [PW-1:0]     r_high_time, w_high_time_d;
  logic              r_meas_valid, w_meas_d;
  logic              r_ovf, w_ovf_d;
  logic              r_glitch, w_glitch_d;

  logic [N:0]        w_ext;
  logic              w_rise_seen, w_rise_multi, w_fall_seen, w_fall_multi;
  logic [HRBITS-1:0] w_rpos, w_fpos;
  logic              w_fall_first, w_do_fall, w_do_rise, w_armed;

  // Edge detection across the word; bit 0 compares against the previous word's last sample.
  always_comb begin
    w_ext        = {bus.din, r_prev_bit};
    w_rise_seen  = 1'b0;
    w_rise_multi = 1'b0;
    w_fall_seen  = 1'b0;
    w_fall_multi = 1'b0;
    w_rpos       = '0;
    w_fpos       = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_ext[i+1] && !w_ext[i]) begin
        w_rise_multi = w_rise_multi | w_rise_seen;
        w_rise_seen  = 1'b1;
        w_rpos       = HRBITS'(i);
      end
      if (!w_ext[i+1] && w_ext[i]) begin
        w_fall_multi = w_fall_multi | w_fall_seen;
        w_fall_seen  = 1'b1;
        w_fpos       = HRBITS'(i);
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_t_rise_d    = r_t_rise;
    w_high_acc_d  = r_high_acc;
    w_period_d    = r_period;
    w_high_time_d = r_high_time;
    w_meas_d      = 1'b0;
    w_ovf_d       = 1'b0;
    w_glitch_d    = 1'b0;
    w_el          = r_elapsed;
    w_armed       = 1'b0;
    w_do_fall     = 1'b0;
    w_do_rise     = 1'b0;
    w_fall_first  = w_fall_seen && (!w_rise_seen || (w_fpos < w_rpos));

    if (w_rise_multi || w_fall_multi) begin
      w_glitch_d = 1'b1;
      w_state_d  = StIdle;
    end else begin
      // Pass 0 handles the earlier edge of the word, pass 1 the later one.
      for (int k = 0; k < 2; k++) begin
        w_do_fall = w_fall_seen && (w_fall_first == (k == 0));
        w_do_rise = w_rise_seen && (w_fall_first != (k == 0));
        if (w_do_fall && (w_state_d == StHigh)) begin
          w_high_acc_d = {w_el, w_fpos} - {{EW{1'b0}}, w_t_rise_d};
          w_state_d    = StLow;
        end
        if (w_do_rise) begin
          if (w_state_d == StLow) begin
            w_period_d    = {w_el, w_rpos} - {{EW{1'b0}}, w_t_rise_d};
            w_high_time_d = w_high_acc_d;
            w_meas_d      = 1'b1;
          end
          // Elapsed is zero for the arming word itself.
          w_t_rise_d = w_rpos;
          w_el       = '0;
          w_armed    = 1'b1;
          w_state_d  = StHigh;
        end
      end
      if (!w_armed && (w_state_d != StIdle) && (r_elapsed == ElMax)) begin
        w_ovf_d   = 1'b1;
        w_state_d = StIdle;
      end
    end

    // The register holds the elapsed count of the next word.
    if (w_armed) begin
      w_elapsed_d = EW'(1);
    end else if (r_elapsed == ElMax) begin
      w_elapsed_d = ElMax;
    end else begin
      w_elapsed_d = r_elapsed + EW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_prev_bit   <= 1'b1;
      r_elapsed    <= '0;
      r_t_rise     <= '0;
      r_high_acc   <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_glitch     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_prev_bit   <= bus.din[N-1];
      r_elapsed    <= w_elapsed_d;
      r_t_rise     <= w_t_rise_d;
      r_high_acc   <= w_high_acc_d;
      r_period     <= w_period_d;
      r_high_time  <= w_high_time_d;
      r_meas_valid <= w_meas_d;
      r_ovf        <= w_ovf_d;
      r_glitch     <= w_glitch_d;
    end
  end

  assign bus.period     = r_period;
  assign bus.high_time  = r_high_time;
  assign bus.meas_valid = r_meas_valid;
  assign bus.ovf        = r_ovf;
  assign bus.glitch     = r_glitch;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: builds the line sample by sample,
// queues the expected events with the word that must trigger them, and
// compares every reported event against the queue.
module tb_pwm_capture;
  localparam int unsigned WIDTH  = 17;
  localparam int unsigned HRBITS = 3;
  localparam int          EMAX   = 8191;

  localparam logic [2:0] KMeas   = 3'b001;
  localparam logic [2:0] KOvf    = 3'b010;
  localparam logic [2:0] KGlitch = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    int          widx;
    logic [15:0] per;
    logic [15:0] hi;
  } exp_t;

  logic clk;
  logic rst;
  pwm_capture_if #(.WIDTH(WIDTH), .HRBITS(HRBITS)) bus ();

  pwm_capture #(.WIDTH(WIDTH), .HRBITS(HRBITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  logic [7:0]  acc;
  int          fill = 0;
  int          tf = 0;
  int          din_idx = -1;
  int          cap_idx = -1;
  logic        cap_rst = 1'b0;
  logic        rst_pend = 1'b1;
  int          last_r = 0;
  int          last_f = 0;
  logic [15:0] last_p = '0;
  logic [15:0] last_h = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [7:0] w);
    @(posedge clk);
    #1;
    bus.din = w;
    rst     = rst_pend;
    din_idx = tf / 8 - 1;
  endtask

  task automatic emit(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      acc[fill] = lvl;
      fill++;
      tf++;
      if (fill == 8) begin
        put_word(acc);
        fill = 0;
      end
    end
  endtask

  // Pad with low samples so the next sample lands at word position pos.
  task automatic align(input int pos);
    emit(1'b0, (pos + 8 - (tf % 8)) % 8);
  endtask

  task automatic push(input logic [2:0] kind, input int widx);
    exp_t e;
    e.kind = kind;
    e.widx = widx;
    e.per  = last_p;
    e.hi   = last_h;
    exp_q.push_back(e);
  endtask

  // One high/low cycle starting with a rising edge; measure means the rising
  // edge closes the previous cycle.
  task automatic pulse(input int hi, input int lo, input bit measure);
    int tr;
    tr = tf;
    if (measure) begin
      last_p = 16'(tr - last_r);
      last_h = 16'(last_f - last_r);
      push(KMeas, tr / 8);
    end
    emit(1'b1, hi);
    last_f = tf;
    emit(1'b0, lo);
    last_r = tr;
  endtask

  always @(posedge clk) begin
    cap_idx <= din_idx;
    cap_rst <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    logic [2:0] k;
    k = {bus.glitch, bus.ovf, bus.meas_valid};
    if (cap_rst) begin
      check("rst_period", 32'(bus.period), 32'd0);
      check("rst_high", 32'(bus.high_time), 32'd0);
      check("rst_flags", 32'(k), 32'd0);
    end else if (k != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("spurious_evt", 32'(k), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", 32'(k), 32'(e.kind));
        check("evt_word", 32'(cap_idx), 32'(e.widx));
        check("evt_period", 32'(bus.period), 32'(e.per));
        check("evt_high", 32'(bus.high_time), 32'(e.hi));
      end
    end
  end

  initial begin
    int tr;
    int n;
    bus.din = '0;
    rst     = 1'b1;

    // Reset held for two words.
    emit(1'b0, 16);
    rst_pend = 1'b0;

    // Period 100 clk, high 50 clk, edges at position 0.
    emit(1'b0, 40);
    pulse(400, 400, 1'b0);
    pulse(400, 400, 1'b1);
    pulse(400, 400, 1'b1);
    pulse(400, 400, 1'b1);

    // Rise at pos 3, fall at pos 5 twelve clocks later, next rise 40 clocks after.
    align(3);
    pulse(98, 222, 1'b1);
    // Rise and fall in the same word while LOW (rise first).
    align(3);
    pulse(3, 74, 1'b1);
    // Fall then rise in the same word while HIGH.
    align(0);
    pulse(13, 2, 1'b1);
    pulse(20, 20, 1'b1);

    // Glitch word 0101_0000 while LOW.
    align(4);
    push(KGlitch, tf / 8);
    emit(1'b1, 1);
    emit(1'b0, 1);
    emit(1'b1, 1);
    emit(1'b0, 1);
    emit(1'b0, 16);
    pulse(50, 70, 1'b0);
    pulse(40, 60, 1'b1);

    // Line stuck low after the last fall.
    push(KOvf, last_r / 8 + EMAX);
    n = (last_r / 8 + EMAX + 3) * 8 - tf;
    emit(1'b0, n);

    // Line stuck high after a rise.
    tr = tf;
    push(KOvf, tr / 8 + EMAX);
    emit(1'b1, 8 * (EMAX + 3));
    emit(1'b0, 16);

    // Reset for one word mid-HIGH with the line held high.
    emit(1'b1, 80);
    rst_pend = 1'b1;
    emit(1'b1, 8);
    rst_pend = 1'b0;
    last_p = '0;
    last_h = '0;
    emit(1'b1, 40);
    emit(1'b0, 40);
    pulse(30, 50, 1'b0);
    pulse(30, 50, 1'b1);
    emit(1'b0, 16);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
